muldiv_iter_unit: RTL and testbench

Parametrised iterative multiply/divide unit for the EX stage. It executes MULT, MULTU, DIV and DIVU with a start/ready handshake and a configurable multiply step. It also provides annul support and explicit divide-by-zero reporting. Results are delivered as HI/LO words for the HI/LO write path. While busy_o is high, EX raises its stall request.

---
 rtl/muldiv_iter_unit.sv | 172 +++++++++++++++++
 tb/tb_muldiv_iter_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_iter_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_iter_unit
// Purpose  : Iterative MULT/MULTU/DIV/DIVU unit producing HI/LO results.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_iter_unit #(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] opdata1_i,
  input  logic [WIDTH-1:0] opdata2_i,
  input  logic             annul_i,
  output logic             busy_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_zero_o
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_FIX  = 2'd2;
  localparam logic [1:0] c_DONE = 2'd3;

  localparam int c_CW = $clog2(WIDTH + 1);
  localparam int c_PW = WIDTH + MUL_STEP;
  localparam logic [c_CW-1:0] c_N_MUL = c_CW'(WIDTH / MUL_STEP);
  localparam logic [c_CW-1:0] c_N_DIV = c_CW'(WIDTH);

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic [c_CW-1:0]    r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dz_pend;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_dz;

  logic               w_sign1;
  logic               w_sign2;
  logic [WIDTH-1:0]   w_mag1;
  logic [WIDTH-1:0]   w_mag2;
  logic               w_accept;
  logic               w_dz_start;
  logic               w_run_start;

  assign w_sign1     = ~op_i[0] & opdata1_i[WIDTH-1];
  assign w_sign2     = ~op_i[0] & opdata2_i[WIDTH-1];
  assign w_mag1      = w_sign1 ? -opdata1_i : opdata1_i;
  assign w_mag2      = w_sign2 ? -opdata2_i : opdata2_i;
  // A pending divide-by-zero completion blocks new starts for its single cycle.
  assign w_accept    = start_i & ~annul_i & ~r_dz_pend &
                       ((r_state == c_IDLE) | (r_state == c_DONE));
  assign w_dz_start  = w_accept & op_i[1] & (opdata2_i == '0);
  assign w_run_start = w_accept & ~w_dz_start;

  // Shift-add: multiplier sits in the low half of the accumulator.
  logic [MUL_STEP-1:0] w_digit;
  logic [c_PW-1:0]     w_msum;
  logic [2*WIDTH-1:0]  w_mul_next;

  assign w_digit    = r_acc[MUL_STEP-1:0];
  assign w_msum     = c_PW'(r_acc[2*WIDTH-1:WIDTH]) + c_PW'(r_a) * c_PW'(w_digit);
  assign w_mul_next = {w_msum, r_acc[WIDTH-1:MUL_STEP]};

  // Restoring division: remainder in the high half, dividend/quotient low.
  logic [WIDTH:0]      w_rem_sh;
  logic                w_ge;
  logic [WIDTH-1:0]    w_new_rem;
  logic [2*WIDTH-1:0]  w_div_next;

  assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_ge       = w_rem_sh >= {1'b0, r_b};
  assign w_new_rem  = w_ge ? WIDTH'(w_rem_sh - {1'b0, r_b}) : w_rem_sh[WIDTH-1:0];
  assign w_div_next = {w_new_rem, r_acc[WIDTH-2:0], w_ge};

  logic [2*WIDTH-1:0]  w_prod;
  logic [WIDTH-1:0]    w_quot;
  logic [WIDTH-1:0]    w_rem;

  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quot = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: begin
        if (r_dz_pend)        w_next_state = c_DONE;
        else if (w_run_start) w_next_state = c_RUN;
      end
      c_RUN: begin
        if (annul_i)                     w_next_state = c_IDLE;
        else if (r_cnt == c_CW'(1))      w_next_state = c_FIX;
      end
      c_FIX: begin
        w_next_state = annul_i ? c_IDLE : c_DONE;
      end
      c_DONE: begin
        w_next_state = w_run_start ? c_RUN : c_IDLE;
      end
      default: w_next_state = c_IDLE;
    endcase
  end

  always_comb begin
    busy_o  = (r_state == c_RUN) | (r_state == c_FIX);
    ready_o = (r_state == c_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_is_div  <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_dz_pend <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_dz      <= 1'b0;
    end else if (w_accept) begin
      // Divide-by-zero reports the raw dividend, so keep it unmodified.
      r_a       <= w_dz_start ? opdata1_i : w_mag1;
      r_b       <= w_mag2;
      r_acc     <= {{WIDTH{1'b0}}, (op_i[1] ? w_mag1 : w_mag2)};
      r_is_div  <= op_i[1];
      r_neg_q   <= w_sign1 ^ w_sign2;
      r_neg_r   <= w_sign1;
      r_cnt     <= op_i[1] ? c_N_DIV : c_N_MUL;
      r_dz      <= 1'b0;
      r_dz_pend <= w_dz_start;
    end else if (r_dz_pend) begin
      r_dz_pend <= 1'b0;
      r_hi      <= r_a;
      r_lo      <= '1;
      r_dz      <= 1'b1;
    end else if ((r_state == c_RUN) && !annul_i) begin
      r_acc     <= r_is_div ? w_div_next : w_mul_next;
      r_cnt     <= r_cnt - c_CW'(1);
    end else if ((r_state == c_FIX) && !annul_i) begin
      r_hi      <= r_is_div ? w_rem  : w_prod[2*WIDTH-1:WIDTH];
      r_lo      <= r_is_div ? w_quot : w_prod[WIDTH-1:0];
    end
  end

  assign hi_o       = r_hi;
  assign lo_o       = r_lo;
  assign div_zero_o = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_iter_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_iter_unit
// Purpose  : Directed checks of muldiv_iter_unit with MUL_STEP=1 and MUL_STEP=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_iter_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;

  logic        busy1, ready1, dz1;
  logic [31:0] hi1, lo1;
  logic        busy4, ready4, dz4;
  logic [31:0] hi4, lo4;

  int n_pass  = 0;
  int n_total = 0;

  muldiv_iter_unit #(.WIDTH(32), .MUL_STEP(1)) u_dut1 (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .annul_i(annul_i),
    .busy_o(busy1), .ready_o(ready1), .hi_o(hi1), .lo_o(lo1), .div_zero_o(dz1)
  );

  muldiv_iter_unit #(.WIDTH(32), .MUL_STEP(4)) u_dut4 (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .annul_i(annul_i),
    .busy_o(busy4), .ready_o(ready4), .hi_o(hi4), .lo_o(lo4), .div_zero_o(dz4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation and tracks both instances until each pulses ready_o.
  // A non-zero glitch puts a stray start_i on that cycle of RUN.
  task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                     input logic edz, input int elat1, input int elat4, input int glitch);
    int          lat1 = 0;
    int          lat4 = 0;
    logic [31:0] h1 = 'x, l1 = 'x, h4 = 'x, l4 = 'x;
    logic        d1 = 1'bx, d4 = 1'bx;
    op_i = op; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    opdata1_i = $urandom; opdata2_i = $urandom; op_i = 2'($urandom);
    check({tag, ".busy_at_start"}, 64'(busy1), 64'(elat1 > 1));
    check({tag, ".dz_cleared"}, 64'(dz1), 64'(0));
    for (int k = 1; k <= 40 && (lat1 == 0 || lat4 == 0); k++) begin
      if (k == glitch) start_i = 1'b1;
      tick();
      start_i = 1'b0;
      if (ready1 && lat1 == 0) begin lat1 = k; h1 = hi1; l1 = lo1; d1 = dz1; end
      if (ready4 && lat4 == 0) begin lat4 = k; h4 = hi4; l4 = lo4; d4 = dz4; end
    end
    check({tag, ".lat1"}, 64'(lat1), 64'(elat1));
    check({tag, ".res1"}, {h1, l1}, {ehi, elo});
    check({tag, ".dz1"},  64'(d1), 64'(edz));
    check({tag, ".lat4"}, 64'(lat4), 64'(elat4));
    check({tag, ".res4"}, {h4, l4}, {ehi, elo});
    check({tag, ".dz4"},  64'(d4), 64'(edz));
  endtask

  initial begin
    int pulses;
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; op_i = 2'b00;
    opdata1_i = 32'h1234_5678; opdata2_i = 32'h9abc_def0;
    repeat (3) tick();
    check("reset.busy",  64'(busy1),  64'(0));
    check("reset.ready", 64'(ready1), 64'(0));
    check("reset.hilo",  {hi1, lo1},  64'(0));
    check("reset.dz",    64'(dz1),    64'(0));
    rst = 1'b0;
    tick();

    run("mult_7_m3", 2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33, 9, 0);
    tick();

    // start together with annul in IDLE is ignored; annul alone in IDLE is harmless
    start_i = 1'b1; annul_i = 1'b1; op_i = 2'b01; opdata1_i = 32'd2; opdata2_i = 32'd2;
    tick();
    start_i = 1'b0;
    check("start_annul.busy", 64'(busy1), 64'(0));
    tick();
    annul_i = 1'b0;
    check("start_annul.ready", 64'(ready1), 64'(0));
    check("start_annul.hold", {hi1, lo1}, 64'hFFFF_FFFF_FFFF_FFEB);

    run("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33, 9, 0);
    tick();
    run("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, 33, 5);
    tick();
    run("div_min_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 33, 33, 0);
    tick();
    run("divu_zero", 2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1, 1, 1, 0);
    tick();
    check("divu_zero.ready_one_cycle", 64'(ready1), 64'(0));
    check("divu_zero.dz_held", 64'(dz1), 64'(1));
    run("multu_3_5", 2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 33, 9, 0);
    tick();

    // DIVU 9/2 annulled mid-RUN, with a stray start ignored before that
    op_i = 2'b11; opdata1_i = 32'd9; opdata2_i = 32'd2; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("annul.busy_run", 64'(busy1), 64'(1));
    repeat (4) tick();
    start_i = 1'b1; op_i = 2'b01; opdata1_i = 32'd6; opdata2_i = 32'd7;
    tick();
    start_i = 1'b0;
    repeat (5) tick();
    annul_i = 1'b1;
    tick();
    annul_i = 1'b0;
    check("annul.busy1", 64'(busy1), 64'(0));
    check("annul.busy4", 64'(busy4), 64'(0));
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      if (ready1 || ready4) pulses++;
      tick();
    end
    check("annul.no_ready", 64'(pulses), 64'(0));
    check("annul.hold1", {hi1, lo1}, 64'd15);
    check("annul.hold4", {hi4, lo4}, 64'd15);

    // back-to-back: second run starts in the DONE cycle of the first
    run("b2b_first", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 33, 9, 0);
    run("b2b_second", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 33, 9, 0);
    tick();

    // reset mid-RUN
    op_i = 2'b00; opdata1_i = 32'd11; opdata2_i = 32'd13; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check("rst_mid.busy",  64'(busy1),  64'(0));
    check("rst_mid.ready", 64'(ready1), 64'(0));
    check("rst_mid.hilo1", {hi1, lo1},  64'(0));
    check("rst_mid.hilo4", {hi4, lo4},  64'(0));
    check("rst_mid.dz",    64'(dz1),    64'(0));
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
